serial_mod_checker: RTL
=======================

Name: serial_mod_checker

Overview:
- Parametrised successor to the fixed divide-by-five serial FSM.
- Accepts a framed serial bit stream on a valid/ready handshake and tracks the running residue modulo a divisor that is programmable at run time.
- Supports MSB-first and LSB-first bit order.
- At frame end it reports residue, a divisible flag, frame length and an error flag; it sits between a serial input pin group and the uo_out status bits of the top.

Parameters:
- MOD_W, 8, width of divisor and residue (divisor range 0..2^MOD_W-1).
- LEN_W, 16, width of the frame bit counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- divisor  input  MOD_W  modulus N; latched on the first accepted bit of a frame.
- lsb_first  input  1  0 = MSB-first, 1 = LSB-first; latched with divisor.
- in_valid  input  1  in_bit/in_last valid this cycle.
- in_bit  input  1  serial data bit.
- in_last  input  1  marks the final bit of the frame.
- in_ready  output  1  block can accept a bit this cycle.
- res_valid  output  1  one-cycle pulse; result outputs updated.
- residue  output  MOD_W  value mod N of the last completed frame.
- divisible  output  1  residue==0 and no error for the last frame.
- bit_count  output  LEN_W  bits in the last completed frame, saturating.
- err  output  1  last frame had divisor==0 or a bit-count overflow.

Behaviour:
- A bit is accepted when in_valid && in_ready on a rising clk.
- in_ready = !rst && state!=DONE.
- The state machine has three states:
  - IDLE: on an accepted bit, latch divisor into N_q and lsb_first into mode_q, clear the frame error, then process the bit (steps below) with r=0, w=1 mod N_q, cnt=0. If in_last is also set, go to DONE; otherwise go to RUN.
  - RUN: each accepted bit updates r, w and cnt. An accepted bit with in_last goes to DONE. Cycles with in_valid=0 hold all state; gaps are legal.
  - DONE: lasts exactly one cycle. res_valid=1; residue, divisible, bit_count and err are registered from the frame. in_ready=0. Next state is IDLE.
- Arithmetic: every step uses an MOD_W+1-bit intermediate and one conditional subtract of N_q; no divider.
  - MSB-first: r' = (2r + b) mod N.
  - LSB-first: r' = (r + b·w) mod N, then w' = 2w mod N.
  - The initial w is 1 mod N, which is 0 when N==1.
- Special divisors:
  - N_q==0: r and w are forced to 0, frame err=1, and at DONE residue=0 and divisible=0.
  - N_q==1: residue is always 0 and divisible=1.
- Bit counter:
  - cnt increments per accepted bit.
  - At all-ones it saturates and sets frame err=1; the frame continues to in_last.
- divisor or lsb_first changing mid-frame has no effect until the next frame.
- Result outputs hold their values until the next DONE.
- Reset:
  - state=IDLE; residue, divisible, bit_count, err and res_valid are all 0.
  - A reset mid-frame discards the frame and produces no res_valid.
  - in_ready=0 while rst=1.
- The latency from accepting the last bit to the res_valid pulse is exactly 1 cycle.

Test Plan:
- MSB-first, N=5, bits 1,1,1,1 with in_last on the 4th (value 15) -> next cycle res_valid=1, residue=0, divisible=1, bit_count=4, err=0.
- LSB-first, N=7, bits 0,1,0,1 (value 10) -> residue=3, divisible=0, bit_count=4. Repeat MSB-first with 1,0,1,0 -> same result.
- N=3, single-bit frame: bit 0 with in_last on the first beat -> residue=0, divisible=1, bit_count=1. in_ready=0 in the DONE cycle, so a bit offered then is not accepted and is taken the following cycle as a new frame.
- Divisor corner cases:
  - N=0, bits 1,1 -> err=1, residue=0, divisible=0.
  - N=1, bits 1,0,1 -> residue=0, divisible=1, err=0.
- Reset mid-frame: assert rst after 3 bits -> no res_valid, outputs 0. Then send a fresh MSB-first N=5 frame 1,0,1,0 (value 10) -> residue=0, divisible=1.
- Robustness with LEN_W=4, N=5 MSB-first:
  - Change divisor to 3 mid-frame and insert in_valid gaps; the result must still be computed mod 5.
  - A 20-bit frame -> bit_count=15 (saturated), err=1, divisible=0.

Source files
------------

// File: rtl/serial_mod_checker.sv
// Serial residue checker: tracks a framed bit stream modulo a run-time divisor,
// MSB- or LSB-first, and reports residue/divisible/length/error at frame end.
module serial_mod_checker #(
    parameter int MOD_W = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MOD_W-1:0] divisor,
    input  logic             lsb_first,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             in_ready,
    output logic             res_valid,
    output logic [MOD_W-1:0] residue,
    output logic             divisible,
    output logic [LEN_W-1:0] bit_count,
    output logic             err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [MOD_W-1:0] n_q, n_d;
    logic             mode_q, mode_d;
    logic [MOD_W-1:0] r_q, r_d;
    logic [MOD_W-1:0] w_q, w_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ferr_q, ferr_d;
    logic [MOD_W-1:0] residue_q, residue_d;
    logic             divisible_q, divisible_d;
    logic [LEN_W-1:0] bit_count_q, bit_count_d;
    logic             err_q, err_d;

    logic             accept, first;
    logic [MOD_W-1:0] n_eff, r_base, w_base, r_new, w_new;
    logic             mode_eff, ferr_base, ferr_new;
    logic [LEN_W-1:0] cnt_base, cnt_new;
    logic [MOD_W:0]   t_r, t_w;

    assign in_ready  = !rst && (state_q != DONE);
    assign res_valid = (state_q == DONE);
    assign residue   = residue_q;
    assign divisible = divisible_q;
    assign bit_count = bit_count_q;
    assign err       = err_q;

    // In IDLE the step runs on freshly latched frame context rather than the stale registers.
    always_comb begin
        accept    = in_valid && in_ready;
        first     = (state_q == IDLE);
        n_eff     = first ? divisor : n_q;
        mode_eff  = first ? lsb_first : mode_q;
        r_base    = first ? '0 : r_q;
        w_base    = first ? ((divisor == MOD_W'(1)) ? '0 : MOD_W'(1)) : w_q;
        cnt_base  = first ? '0 : cnt_q;
        ferr_base = first ? 1'b0 : ferr_q;

        if (mode_eff) begin
            t_r = {1'b0, r_base} + (in_bit ? {1'b0, w_base} : '0);
        end else begin
            t_r = {r_base, in_bit};
        end
        t_w = {w_base, 1'b0};

        // One conditional subtract; low bits of (t - N) equal (low bits of t) - N.
        r_new = (t_r >= {1'b0, n_eff}) ? (t_r[MOD_W-1:0] - n_eff) : t_r[MOD_W-1:0];
        w_new = (t_w >= {1'b0, n_eff}) ? (t_w[MOD_W-1:0] - n_eff) : t_w[MOD_W-1:0];
        if (n_eff == '0) begin
            r_new = '0;
            w_new = '0;
        end
        if (!mode_eff) begin
            w_new = w_base;
        end

        cnt_new  = (cnt_base == '1) ? cnt_base : cnt_base + LEN_W'(1);
        ferr_new = ferr_base || (n_eff == '0) || (cnt_base == '1);

        state_d     = state_q;
        n_d         = n_q;
        mode_d      = mode_q;
        r_d         = r_q;
        w_d         = w_q;
        cnt_d       = cnt_q;
        ferr_d      = ferr_q;
        residue_d   = residue_q;
        divisible_d = divisible_q;
        bit_count_d = bit_count_q;
        err_d       = err_q;

        case (state_q)
            IDLE, RUN: begin
                if (accept) begin
                    n_d    = n_eff;
                    mode_d = mode_eff;
                    r_d    = r_new;
                    w_d    = w_new;
                    cnt_d  = cnt_new;
                    ferr_d = ferr_new;
                    if (in_last) begin
                        state_d     = DONE;
                        residue_d   = r_new;
                        divisible_d = (r_new == '0) && !ferr_new;
                        bit_count_d = cnt_new;
                        err_d       = ferr_new;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            mode_q      <= 1'b0;
            r_q         <= '0;
            w_q         <= '0;
            cnt_q       <= '0;
            ferr_q      <= 1'b0;
            residue_q   <= '0;
            divisible_q <= 1'b0;
            bit_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            mode_q      <= mode_d;
            r_q         <= r_d;
            w_q         <= w_d;
            cnt_q       <= cnt_d;
            ferr_q      <= ferr_d;
            residue_q   <= residue_d;
            divisible_q <= divisible_d;
            bit_count_q <= bit_count_d;
            err_q       <= err_d;
        end
    end

endmodule
